// File: rtl/crc5_frame_checker_pkg.sv
// Shared CRC-5 definitions for the nibble datapath: widths, default polynomial,
// checker FSM states and the MSB-first nibble step function.
package crc5_pkg;

  localparam int CRC_W = 5;
  localparam int NIB_W = 4;
  localparam logic [CRC_W-1:0] DEFAULT_POLY = 5'h05;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT_CRC,
    REPORT
  } state_t;

  // Shifts one nibble into the CRC, bit 3 first, no reflection and no final XOR.
  function automatic logic [CRC_W-1:0] crc5_step(
    input logic [CRC_W-1:0] crc,
    input logic [NIB_W-1:0] nib,
    input logic [CRC_W-1:0] poly
  );
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = NIB_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ nib[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc5_frame_checker_if.sv
// Handshake and result bundle between the upstream nibble source and the checker.
interface crc5_frame_checker_if;
  import crc5_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [NIB_W-1:0] in_data;
  logic             in_last;
  logic             crc_valid;
  logic             crc_ready;
  logic [CRC_W-1:0] crc_in;
  logic             res_valid;
  logic             res_ok;
  logic             res_len_err;
  logic [7:0]       res_len;

  modport master (
    output in_valid, in_data, in_last, crc_valid, crc_in,
    input  in_ready, crc_ready, res_valid, res_ok, res_len_err, res_len
  );

  modport slave (
    input  in_valid, in_data, in_last, crc_valid, crc_in,
    output in_ready, crc_ready, res_valid, res_ok, res_len_err, res_len
  );

endinterface

// File: rtl/crc5_frame_checker_nibble_step.sv
// Combinational one-nibble CRC-5 update, shared between generator and checker.
module crc5_nibble_step
  import crc5_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic [CRC_W-1:0] crc_prev,
  input  logic [NIB_W-1:0] nibble,
  output logic [CRC_W-1:0] crc_next
);

  assign crc_next = crc5_step(crc_prev, nibble, POLY);

endmodule

// File: rtl/crc5_frame_checker.sv
// Receive-side CRC-5 frame checker with length limit; optional failed-frame
// counter enabled by defining CRC_ERR_CNT_EN.
module crc5_frame_checker
  import crc5_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY    = DEFAULT_POLY,
  parameter logic [CRC_W-1:0] INIT    = 5'h00,
  parameter int               MAX_LEN = 16
`ifdef CRC_ERR_CNT_EN
  ,
  parameter int               CNT_W   = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  crc5_frame_checker_if.slave bus
`ifdef CRC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]   err_count
`endif
);

  state_t           state, next_state;
  logic [CRC_W-1:0] crc_q, crc_d, step_prev, step_out;
  logic [7:0]       len_q, len_d;
  logic             in_ready, crc_ready;
  logic             rep_load, rep_ok, rep_len_err;
  logic [7:0]       rep_len;
  logic             res_valid_q, res_ok_q, res_len_err_q;
  logic [7:0]       res_len_q;

  // The first nibble of a frame always starts from INIT, whatever the register holds.
  assign step_prev = (state == IDLE) ? INIT : crc_q;

  crc5_nibble_step #(.POLY(POLY)) u_step (
    .crc_prev (step_prev),
    .nibble   (bus.in_data),
    .crc_next (step_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      crc_q         <= INIT;
      len_q         <= '0;
      res_valid_q   <= 1'b0;
      res_ok_q      <= 1'b0;
      res_len_err_q <= 1'b0;
      res_len_q     <= '0;
    end else begin
      state       <= next_state;
      crc_q       <= crc_d;
      len_q       <= len_d;
      res_valid_q <= rep_load;
      if (rep_load) begin
        res_ok_q      <= rep_ok;
        res_len_err_q <= rep_len_err;
        res_len_q     <= rep_len;
      end
    end
  end

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    crc_ready   = 1'b0;
    crc_d       = crc_q;
    len_d       = len_q;
    rep_load    = 1'b0;
    rep_ok      = 1'b0;
    rep_len_err = 1'b0;
    rep_len     = len_q;
    case (state)
      IDLE, DATA: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          crc_d = step_out;
          len_d = len_q + 8'd1;
          if (bus.in_last) begin
            next_state = WAIT_CRC;
          end else if (len_d == 8'(MAX_LEN)) begin
            // Overlong frame: report immediately, no CRC field is taken.
            next_state  = REPORT;
            rep_load    = 1'b1;
            rep_len_err = 1'b1;
            rep_len     = len_d;
          end else begin
            next_state = DATA;
          end
        end
      end
      WAIT_CRC: begin
        crc_ready = 1'b1;
        if (bus.crc_valid) begin
          next_state = REPORT;
          rep_load   = 1'b1;
          rep_ok     = (crc_q == bus.crc_in);
          rep_len    = len_q;
        end
      end
      REPORT: begin
        next_state = IDLE;
        crc_d      = INIT;
        len_d      = '0;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.crc_ready   = crc_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_ok      = res_ok_q;
  assign bus.res_len_err = res_len_err_q;
  assign bus.res_len     = res_len_q;

`ifdef CRC_ERR_CNT_EN
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (res_valid_q && !res_ok_q && !(&err_q)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: doc/crc5_frame_checker.md
# crc5_frame_checker

Receive-side checker that sits directly downstream of the parallel CRC-5 generator in the nibble datapath. It consumes a framed stream of 4-bit data nibbles followed by a 5-bit CRC field. It recomputes CRC-5 over the data, one nibble per cycle, and reports per frame whether the received CRC matches, along with the frame length. It also flags frames that exceed the length limit.

## Interface
Parameters:
- POLY, 5'h05, CRC-5 generator polynomial (x^5+x^2+1), implicit x^5 term.
- INIT, 5'h00, CRC register value at frame start.
- MAX_LEN, 16, maximum data nibbles per frame (2..255).
- CNT_W, 8, width of error counter.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  data nibble valid.
- in_ready  output  1  checker can accept a data nibble.
- in_data  input  4  data nibble, bit 3 processed first.
- in_last  input  1  qualifies the final data nibble of a frame.
- crc_valid  input  1  received CRC field valid.
- crc_ready  output  1  checker can accept the CRC field.
- crc_in  input  5  received CRC field.
- res_valid  output  1  one-cycle result pulse.
- res_ok  output  1  computed CRC equals crc_in; valid with res_valid.
- res_len_err  output  1  frame exceeded MAX_LEN; valid with res_valid.
- res_len  output  8  data nibbles in the frame; valid with res_valid.
- err_count  output  CNT_W  saturating count of failed frames (present only with CRC_ERR_CNT_EN).

## Operation
- FSM states: IDLE, DATA, WAIT_CRC, REPORT.
- **IDLE / DATA:**
  - in_ready=1.
  - On in_valid&in_ready: crc <= step(crc, in_data) and len <= len+1.
  - In IDLE the step uses INIT as the prior CRC value; in DATA it uses the running register.
- **Step function:** MSB-first, no reflection, no final XOR. For each bit b from in_data[3] down to in_data[0]: fb = crc[4]^b, crc = {crc[3:0],1'b0} ^ (fb ? POLY : 0).
- **DATA transitions:**
  - Accepted nibble with in_last=1 → WAIT_CRC.
  - Accepted nibble without in_last, and len reaching MAX_LEN → REPORT with len error.
  - Otherwise stay in DATA.
- **WAIT_CRC:**
  - in_ready=0, crc_ready=1.
  - On crc_valid: latch the compare result → REPORT.
- **REPORT:**
  - res_valid=1 for exactly one cycle; all other ready signals are 0.
  - Next state IDLE; crc is reloaded with INIT and len is cleared.
- **res_ok:** equals (crc == crc_in) only for a normally terminated frame; it is 0 whenever res_len_err=1.
- **Length error:** no CRC field is consumed. Further upstream nibbles start a new frame after REPORT.
- **Input gating:** crc_valid outside WAIT_CRC is ignored. in_valid while in_ready=0 is held by upstream (standard valid/ready, no drop).
- **Single-nibble frame:** in_valid with in_last in IDLE is a 1-nibble frame, res_len=1.

## Timing
- **Reset** (rst low, async): state=IDLE, crc=INIT, len=0, in_ready=1, crc_ready=0, res_valid=0, res_ok=0, res_len_err=0, res_len=0, err_count=0.
- **Throughput:** one data nibble per cycle.
- **Latency:** res_valid is asserted 1 cycle after the CRC handshake, or 1 cycle after the overflowing nibble.
- **Frame overhead:** minimum 2 cycles (WAIT_CRC handshake and REPORT) between the last nibble and the next frame's first nibble.
- **Result outputs:** registered, and hold their last value after the pulse.
- **Reset mid-frame:** the partial frame is discarded; no res_valid is produced.

## Configuration
- CRC_ERR_CNT_EN defined:
  - err_count port and counter are present.
  - The counter increments by 1 on each res_valid with res_ok=0, saturating at all-ones.
- Undefined: the port and counter are absent; all other behaviour is unchanged.

## Structure
- Shared package crc5_pkg holds:
  - the state enum;
  - CRC_W=5 and NIB_W=4 constants;
  - a default POLY constant;
  - the step function.
- One sub-module, crc5_nibble_step: combinational 4-bit-per-cycle CRC update instantiated by the FSM. It is shared with the generator side.

## Test plan
- Frame {4'h1}, last, crc_in=5'h05 → res_valid one cycle after CRC accept, res_ok=1, res_len=1, res_len_err=0.
- Frame {4'h1,4'h0}, crc_in=5'h1A → res_ok=1, res_len=2.
- Same frame with crc_in=5'h1B → res_ok=0; err_count increments to 1 (macro on).
- 16 nibbles without in_last (MAX_LEN=16) → res_len_err=1, res_ok=0, res_len=16, crc_ready never asserted; the next nibble starts a fresh frame.
- Assert rst low in WAIT_CRC, then frame {4'h1}/5'h05 → no result from the aborted frame; the new frame gives res_ok=1.
- Back-to-back frames with in_valid held high, plus crc_valid pulses outside WAIT_CRC → in_ready drops for exactly WAIT_CRC+REPORT; stray crc_valid is ignored; both frames report correctly.
